// File: rtl/scs8hd_bist_pkg.sv
// Shared definitions for the cell BIST engines.
//   bist_state_e      : engine state encoding (IDLE, HOLD, SAMPLE, DONE)
//   MISR_POLY         : feedback polynomial of the 16-bit signature register
//   MISR_SEED_DEFAULT : signature value loaded on START / reset
//   TRUTH_*           : expected-Y tables for 4-input cells, bit v = Y for vector v
//   misr_next()       : one signature step for a single data bit
package scs8hd_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  localparam logic [15:0] MISR_POLY         = 16'h1021;
  localparam logic [15:0] MISR_SEED_DEFAULT = 16'hFFFF;

  // Y = !((!A1N & !A2N) | (B1 & B2)), A[0]=A1N A[1]=A2N A[2]=B1 A[3]=B2
  localparam logic [15:0] TRUTH_A2BB2OI     = 16'h0EEE;

  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/scs8hd_bist_misr16.sv
// 16-bit serial-input signature register, reusable by any BIST engine.
//   clk, rst_n : clock, asynchronous active-low reset (resets to RST_VAL)
//   load, seed : synchronous load of seed (has priority over en)
//   en, din    : fold din into the signature on this edge
//   sig        : current signature
module scs8hd_bist_misr16
  import scs8hd_bist_pkg::*;
#(
  parameter logic [15:0] RST_VAL = MISR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/scs8hd_cellbist_4in.sv
// Exhaustive BIST engine for a NUM_IN-input library cell. Drives every input
// vector in order, waits SETTLE_CYC cycles, samples the cell output, checks it
// against TRUTH and folds it into a 16-bit MISR signature.
//   CLK, RESETB : clock, asynchronous active-low reset
//   START       : begin a run (accepted only in IDLE or DONE)
//   CELL_Y      : cell-under-test output
//   CELL_A      : cell-under-test inputs (current vector)
//   BUSY        : run in progress
//   DONE        : run complete, held until next START or reset
//   PASS        : DONE and no mismatches
//   FAIL_CNT    : number of mismatching vectors
//   FIRST_FAIL  : index of first mismatching vector (0 if none)
//   SIGNATURE   : MISR value
module scs8hd_cellbist_4in
  import scs8hd_bist_pkg::*;
#(
  parameter int unsigned                  NUM_IN     = 4,
  parameter int unsigned                  SETTLE_CYC = 2,
  parameter logic [(2**NUM_IN)-1:0]       TRUTH      = TRUTH_A2BB2OI,
  parameter logic [15:0]                  MISR_SEED  = MISR_SEED_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              START,
  input  logic              CELL_Y,
  output logic [NUM_IN-1:0] CELL_A,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [NUM_IN:0]   FAIL_CNT,
  output logic [NUM_IN-1:0] FIRST_FAIL,
  output logic [15:0]       SIGNATURE
);

  localparam logic [NUM_IN-1:0] VEC_LAST  = '1;
  localparam logic [3:0]        HOLD_LAST = 4'(SETTLE_CYC - 1);

  bist_state_e       state, state_nxt;
  logic [NUM_IN-1:0] vec;
  logic [3:0]        hold_cnt;
  logic              y_smp;
  logic [NUM_IN:0]   fail_cnt;
  logic [NUM_IN-1:0] first_fail;
  logic              start_acc;
  logic              sample_en;
  logic              mismatch;

  assign start_acc = START && ((state == ST_IDLE) || (state == ST_DONE));
  assign sample_en = (state == ST_SAMPLE);
  // Case-inequality so an unknown Y is scored as a failure in simulation.
  assign mismatch  = (y_smp !== TRUTH[vec]);

  // State register
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (START) state_nxt = ST_HOLD;
      ST_HOLD:          if (hold_cnt == HOLD_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE:        state_nxt = (vec == VEC_LAST) ? ST_DONE : ST_HOLD;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    unique case (state)
      ST_HOLD, ST_SAMPLE: BUSY = 1'b1;
      ST_DONE:            DONE = 1'b1;
      default:            ;
    endcase
  end

  // Datapath. Y is captured on the edge that ends the settle window (exactly
  // SETTLE_CYC edges after CELL_A changed); the SAMPLE cycle then scores that
  // captured bit, which keeps the per-vector period at SETTLE_CYC+1 cycles.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      vec        <= '0;
      hold_cnt   <= '0;
      y_smp      <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else if (start_acc) begin
      vec        <= '0;
      hold_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 4'd1;
          if (hold_cnt == HOLD_LAST) y_smp <= CELL_Y;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + (NUM_IN+1)'(1);
            if (fail_cnt == '0) first_fail <= vec;
          end
          if (vec != VEC_LAST) begin
            vec      <= vec + NUM_IN'(1);
            hold_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  scs8hd_bist_misr16 #(
    .RST_VAL (MISR_SEED)
  ) u_misr (
    .clk   (CLK),
    .rst_n (RESETB),
    .load  (start_acc),
    .seed  (MISR_SEED),
    .en    (sample_en),
    .din   (y_smp),
    .sig   (SIGNATURE)
  );

  assign CELL_A     = vec;
  assign FAIL_CNT   = fail_cnt;
  assign FIRST_FAIL = first_fail;
  assign PASS       = DONE && (fail_cnt == '0);

endmodule

// File: tb/tb_scs8hd_cellbist_4in.sv
module tb_scs8hd_cellbist_4in;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        cell_y, cell_y2;
  logic [3:0]  cell_a, cell_a2, first_fail, first_fail2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [4:0]  fail_cnt, fail_cnt2;
  logic [15:0] sig, sig2;
  logic        dly, dly2;
  int          mode;   // 0 ideal, 1 stuck-at-1, 2 wrong function, 3 one-cycle delayed
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  scs8hd_cellbist_4in #(
    .NUM_IN(4), .SETTLE_CYC(2), .TRUTH(16'h0EEE), .MISR_SEED(16'hFFFF)
  ) dut (
    .CLK(clk), .RESETB(rst_n), .START(start), .CELL_Y(cell_y), .CELL_A(cell_a),
    .BUSY(busy), .DONE(done), .PASS(pass), .FAIL_CNT(fail_cnt),
    .FIRST_FAIL(first_fail), .SIGNATURE(sig)
  );

  scs8hd_cellbist_4in #(
    .NUM_IN(4), .SETTLE_CYC(1), .TRUTH(16'h0EEE), .MISR_SEED(16'hFFFF)
  ) dut_s1 (
    .CLK(clk), .RESETB(rst_n), .START(start2), .CELL_Y(cell_y2), .CELL_A(cell_a2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_CNT(fail_cnt2),
    .FIRST_FAIL(first_fail2), .SIGNATURE(sig2)
  );

  function automatic logic a2bb2oi(input logic [3:0] a);
    return !((!a[0] && !a[1]) || (a[2] && a[3]));
  endfunction

  always_ff @(posedge clk) begin
    dly  <= a2bb2oi(cell_a);
    dly2 <= a2bb2oi(cell_a2);
  end

  always_comb begin
    cell_y = 1'b0;
    case (mode)
      0: cell_y = a2bb2oi(cell_a);
      1: cell_y = 1'b1;
      2: cell_y = (cell_a[0] || cell_a[1]) || (cell_a[2] && cell_a[3]);
      3: cell_y = dly;
      default: cell_y = 1'b0;
    endcase
  end
  assign cell_y2 = dly2;

  // Reference signature: feed 16 Y bits in vector order through a CRC-style shift.
  function automatic logic [15:0] ref_sig(input logic [15:0] ybits);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      if (s[15] ^ ybits[v]) s = {s[14:0], 1'b0} ^ 16'h1021;
      else                  s = {s[14:0], 1'b0};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse START for one edge, return edges from acceptance until DONE is seen.
  task automatic start_and_wait(output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int          lat, n;
    logic [15:0] sig_a;
    mode   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;

    // Reset values
    #22;
    check("rst_cell_a", cell_a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_first_fail", first_fail, 0);
    check("rst_sig", sig, 16'hFFFF);
    @(negedge clk); rst_n = 1'b1;

    // Ideal cell
    mode = 0;
    start_and_wait(lat);
    check("ideal_lat", lat, 48);
    check("ideal_done", done, 1);
    check("ideal_busy", busy, 0);
    check("ideal_pass", pass, 1);
    check("ideal_fail_cnt", fail_cnt, 0);
    check("ideal_first_fail", first_fail, 0);
    check("ideal_sig", sig, ref_sig(16'h0EEE));

    // Stuck-at-1 output
    mode = 1;
    start_and_wait(lat);
    check("sa1_lat", lat, 48);
    check("sa1_fail_cnt", fail_cnt, 7);
    check("sa1_first_fail", first_fail, 0);
    check("sa1_pass", pass, 0);
    check("sa1_done", done, 1);
    check("sa1_sig", sig, ref_sig(16'hFFFF));

    // Wrong function: B pair drives Y high instead of low
    mode = 2;
    start_and_wait(lat);
    check("wrong_fail_cnt", fail_cnt, 4);
    check("wrong_first_fail", first_fail, 12);
    check("wrong_pass", pass, 0);

    // Async reset mid-run at vector 5 (stuck cell so counters are non-zero)
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (cell_a != 4'd5 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("midrst_reached_vec5", cell_a, 5);
    check("midrst_fail_before", fail_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cell_a", cell_a, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    check("midrst_first_fail", first_fail, 0);
    check("midrst_sig", sig, 16'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    mode = 0;
    start_and_wait(lat);
    check("postrst_lat", lat, 48);
    check("postrst_pass", pass, 1);
    check("postrst_sig", sig, ref_sig(16'h0EEE));

    // START pulses while busy are ignored
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat >= 10 && lat < 13);
      @(posedge clk); #1; lat++;
    end
    start = 1'b0;
    check("busy_start_lat", lat, 48);
    check("busy_start_pass", pass, 1);
    sig_a = sig;

    // START held high through DONE: back-to-back runs
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    check("b2b_first_lat", lat, 48);
    @(posedge clk); #1;
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_done", done, 0);
    start = 1'b0;
    wait_done(lat);
    check("b2b_second_lat", lat, 48);
    check("b2b_sig_same", sig, sig_a);

    // Delayed cell with SETTLE_CYC=2 still passes
    mode = 3;
    start_and_wait(lat);
    check("dly_s2_pass", pass, 1);
    check("dly_s2_fail_cnt", fail_cnt, 0);

    // Delayed cell with SETTLE_CYC=1 sees the previous vector's Y
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("dly_s1_lat", lat, 32);
    check("dly_s1_fail_cnt", fail_cnt2, 6);
    check("dly_s1_first_fail", first_fail2, 1);
    check("dly_s1_pass", pass2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
